wb_data_master: RTL and testbench

//  Wishbone classic initiator for the core data port. Accepts one load/store request at a time

---
 rtl/wb_data_master.sv | 226 ++++++++++++++++++++++
 tb/tb_wb_data_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_data_master.sv
// -----------------------------------------------------------------------------
// wb_data_master
//   Wishbone classic initiator for the core data port. Takes one load/store
//   request at a time from the memory stage, validates funct3 and alignment,
//   runs a single Wishbone cycle, and returns a one-cycle response pulse with
//   extracted/extended load data.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   req_valid/ready request handshake; ready only while idle
//   req_we          1 = store, 0 = load
//   req_funct3      RV32 load/store width encoding
//   req_addr        byte address
//   req_wdata       right-aligned store data
//   rsp_valid       one-cycle response pulse
//   rsp_rdata       extended load data (0 for stores and errors)
//   rsp_err         bus error or timeout
//   rsp_misalign    misaligned address or illegal funct3, no bus cycle issued
//   wb_*            Wishbone classic master signals
// -----------------------------------------------------------------------------
module wb_data_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_misalign,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);

   localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

   state_t             state_q, state_d;
   logic               we_q, we_d;
   logic [2:0]         f3_q, f3_d;
   logic [1:0]         alo_q, alo_d;
   logic [31:0]        adr_q, adr_d;
   logic [31:0]        dat_q, dat_d;
   logic [3:0]         sel_q, sel_d;
   logic               cyc_q, cyc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               err_q, err_d;
   logic               mis_q, mis_d;

   // Legal funct3 for the direction and naturally aligned for its width.
   function automatic logic req_ok(input logic we, input logic [2:0] f3,
                                   input logic [1:0] a);
      logic legal;
      logic aligned;
      if (we) legal = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
      else    legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      case (f3[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~a[0];
         2'b10:   aligned = (a == 2'b00);
         default: aligned = 1'b0;
      endcase
      return legal && aligned;
   endfunction

   function automatic logic [3:0] byte_sel(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b00:   return 4'b0001 << a;
         2'b01:   return 4'b0011 << {a[1], 1'b0};
         default: return 4'b1111;
      endcase
   endfunction

   // Replicate the right-aligned store value across every lane so the slave
   // finds it under whichever byte select is active.
   function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
      case (f3[1:0])
         2'b00:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   // Addresses are already aligned here, so shifting by 8*addr[1:0] also
   // selects the right half for halfword loads.
   function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] d);
      logic [31:0] sh;
      sh = d >> {a, 3'b000};
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b100:  return {24'd0, sh[7:0]};
         3'b101:  return {16'd0, sh[15:0]};
         default: return d;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      alo_d   = alo_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      cyc_d   = cyc_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      mis_d   = mis_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d  = req_we;
               f3_d  = req_funct3;
               alo_d = req_addr[1:0];
               adr_d = {req_addr[31:2], 2'b00};
               dat_d = store_lanes(req_funct3, req_wdata);
               sel_d = byte_sel(req_funct3, req_addr[1:0]);
               if (req_ok(req_we, req_funct3, req_addr[1:0])) begin
                  state_d = S_BUS;
                  cyc_d   = 1'b1;
                  cnt_d   = '0;
               end else begin
                  state_d = S_RESP;
                  rdata_d = '0;
                  err_d   = 1'b0;
                  mis_d   = 1'b1;
               end
            end
         end

         S_BUS: begin
            if (wb_err_i) begin
               // Error takes priority over a simultaneous ack.
               state_d = S_RESP;
               cyc_d   = 1'b0;
               rdata_d = '0;
               err_d   = 1'b1;
               mis_d   = 1'b0;
            end else if (wb_ack_i) begin
               state_d = S_RESP;
               cyc_d   = 1'b0;
               rdata_d = we_q ? 32'd0 : load_extract(f3_q, alo_q, wb_dat_i);
               err_d   = 1'b0;
               mis_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if ((TIMEOUT_CYCLES != 0) && (cnt_d == TO_LIM)) begin
                  state_d = S_RESP;
                  cyc_d   = 1'b0;
                  rdata_d = '0;
                  err_d   = 1'b1;
                  mis_d   = 1'b0;
               end
            end
         end

         S_RESP: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   // State / registered outputs boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         alo_q   <= 2'd0;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         cyc_q   <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         alo_q   <= alo_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         cyc_q   <= cyc_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         mis_q   <= mis_d;
      end
   end

   assign req_ready    = (state_q == S_IDLE);
   assign rsp_valid    = (state_q == S_RESP);
   assign rsp_rdata    = rdata_q;
   assign rsp_err      = err_q;
   assign rsp_misalign = mis_q;
   assign wb_adr_o     = adr_q;
   assign wb_dat_o     = dat_q;
   assign wb_we_o      = we_q;
   assign wb_sel_o     = sel_q;
   assign wb_cyc_o     = cyc_q;
   assign wb_stb_o     = cyc_q;

endmodule

// File: tb/tb_wb_data_master.sv
module tb_wb_data_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err, rsp_misalign;
   logic [31:0] rsp_rdata;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
   logic [3:0]  wb_sel_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_data_master #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_misalign(rsp_misalign),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
      .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o),
      .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );

   // Result of one transaction as observed on the pins.
   int          lat, ncyc;
   logic [31:0] o_adr, o_dat, o_rdata;
   logic [3:0]  o_sel;
   logic        o_we, o_stable, o_err, o_mis, o_pulse;

   // Called right after a negedge. Presents a request for one cycle and acts
   // as a slave that acks in the (ack_at+1)-th cycle cyc is seen high, i.e. a
   // registered slave for ack_at=1. ack_at=100 means never.
   task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int ack_at,
                       input logic [31:0] rd, input logic with_err);
      lat = -1; ncyc = 0; o_stable = 1'b1; o_pulse = 1'b0;
      o_adr = '0; o_dat = '0; o_sel = '0; o_we = 1'b0;
      o_rdata = '0; o_err = 1'b0; o_mis = 1'b0;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      for (int n = 1; n <= 40 && lat < 0; n++) begin
         @(negedge clk);
         req_valid = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
         if (wb_stb_o !== wb_cyc_o) o_stable = 1'b0;
         if (rsp_valid) begin
            lat = n; o_rdata = rsp_rdata; o_err = rsp_err; o_mis = rsp_misalign;
         end else if (wb_cyc_o) begin
            ncyc++;
            if (ncyc == 1) begin
               o_adr = wb_adr_o; o_dat = wb_dat_o; o_sel = wb_sel_o; o_we = wb_we_o;
            end else if (wb_adr_o !== o_adr || wb_dat_o !== o_dat ||
                         wb_sel_o !== o_sel || wb_we_o !== o_we) begin
               o_stable = 1'b0;
            end
            if (ncyc == ack_at + 1) begin
               wb_ack_i = 1'b1; wb_err_i = with_err; wb_dat_i = rd;
            end
         end
      end
      if (lat >= 0) begin
         @(negedge clk);
         o_pulse = !rsp_valid && req_ready && !wb_cyc_o && rsp_rdata === o_rdata &&
                   rsp_err === o_err && rsp_misalign === o_mis;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
      total++; if ({wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid, rsp_err, rsp_misalign} !== 6'b0) begin
         bad++; $display("FAIL reset_ctrl got=%b want=000000",
                         {wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid, rsp_err, rsp_misalign});
      end
      total++; if ({wb_adr_o, wb_dat_o, rsp_rdata, wb_sel_o} !== 100'b0) begin
         bad++; $display("FAIL reset_data adr=%h dat=%h rdata=%h sel=%b want=0",
                         wb_adr_o, wb_dat_o, rsp_rdata, wb_sel_o);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_lw();
      xfer(1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF, 1'b0);
      total++; if (lat !== 3) begin bad++; $display("FAIL lw_latency got=%0d want=3", lat); end
      total++; if (o_adr !== 32'h100 || o_sel !== 4'b1111 || o_we !== 1'b0) begin
         bad++; $display("FAIL lw_bus adr=%h sel=%b we=%b want 100/1111/0", o_adr, o_sel, o_we);
      end
      total++; if (o_rdata !== 32'hDEADBEEF || o_err !== 1'b0 || o_mis !== 1'b0) begin
         bad++; $display("FAIL lw_rsp rdata=%h err=%b mis=%b want deadbeef/0/0", o_rdata, o_err, o_mis);
      end
      total++; if (o_pulse !== 1'b1 || o_stable !== 1'b1) begin
         bad++; $display("FAIL lw_pulse_hold pulse=%b stable=%b want 1/1", o_pulse, o_stable);
      end
   endtask

   task automatic test_load_ext();
      xfer(1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF1234, 1'b0);
      total++; if (o_sel !== 4'b1000 || o_rdata !== 32'hFFFFFF80) begin
         bad++; $display("FAIL lb_103 sel=%b rdata=%h want 1000/ffffff80", o_sel, o_rdata);
      end
      xfer(1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF1234, 1'b0);
      total++; if (o_sel !== 4'b1000 || o_rdata !== 32'h00000080) begin
         bad++; $display("FAIL lbu_103 sel=%b rdata=%h want 1000/00000080", o_sel, o_rdata);
      end
      xfer(1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80FF1234, 1'b0);
      total++; if (o_sel !== 4'b1100 || o_rdata !== 32'hFFFF80FF) begin
         bad++; $display("FAIL lh_102 sel=%b rdata=%h want 1100/ffff80ff", o_sel, o_rdata);
      end
      xfer(1'b0, 3'b101, 32'h102, 32'h0, 1, 32'h80FF1234, 1'b0);
      total++; if (o_rdata !== 32'h000080FF) begin
         bad++; $display("FAIL lhu_102 rdata=%h want 000080ff", o_rdata);
      end
      xfer(1'b0, 3'b000, 32'h101, 32'h0, 1, 32'h80FF1234, 1'b0);
      total++; if (o_sel !== 4'b0010 || o_rdata !== 32'h00000012 || o_adr !== 32'h100) begin
         bad++; $display("FAIL lb_101 sel=%b rdata=%h adr=%h want 0010/00000012/100", o_sel, o_rdata, o_adr);
      end
   endtask

   task automatic test_store();
      xfer(1'b1, 3'b001, 32'h1002, 32'h0000ABCD, 1, 32'hFFFFFFFF, 1'b0);
      total++; if (o_adr !== 32'h1000 || o_sel !== 4'b1100 || o_dat !== 32'hABCDABCD || o_we !== 1'b1) begin
         bad++; $display("FAIL sh_bus adr=%h sel=%b dat=%h we=%b want 1000/1100/abcdabcd/1",
                         o_adr, o_sel, o_dat, o_we);
      end
      total++; if (o_rdata !== 32'h0 || o_err !== 1'b0 || lat !== 3) begin
         bad++; $display("FAIL sh_rsp rdata=%h err=%b lat=%0d want 0/0/3", o_rdata, o_err, lat);
      end
      xfer(1'b1, 3'b010, 32'h1000, 32'h00000001, 1, 32'h0, 1'b0);
      total++; if (o_dat !== 32'h1 || o_sel !== 4'b1111 || ncyc !== 2 || o_stable !== 1'b1) begin
         bad++; $display("FAIL sw_bus dat=%h sel=%b ncyc=%0d stable=%b want 1/1111/2/1",
                         o_dat, o_sel, ncyc, o_stable);
      end
      xfer(1'b1, 3'b000, 32'h1001, 32'h1234565A, 1, 32'h0, 1'b0);
      total++; if (o_dat !== 32'h5A5A5A5A || o_sel !== 4'b0010) begin
         bad++; $display("FAIL sb_bus dat=%h sel=%b want 5a5a5a5a/0010", o_dat, o_sel);
      end
   endtask

   task automatic test_misalign();
      logic [35:0] vec [4];
      vec[0] = {1'b0, 3'b010, 32'h102};
      vec[1] = {1'b0, 3'b001, 32'h101};
      vec[2] = {1'b0, 3'b011, 32'h100};
      vec[3] = {1'b1, 3'b011, 32'h100};
      for (int i = 0; i < 4; i++) begin
         xfer(vec[i][35], vec[i][34:32], vec[i][31:0], 32'hFFFFFFFF, 1, 32'h55555555, 1'b0);
         total++; if (lat !== 1 || ncyc !== 0 || o_mis !== 1'b1 || o_err !== 1'b0 || o_rdata !== 32'h0) begin
            bad++; $display("FAIL misalign_%0d lat=%0d ncyc=%0d mis=%b err=%b rdata=%h want 1/0/1/0/0",
                            i, lat, ncyc, o_mis, o_err, o_rdata);
         end
      end
   endtask

   task automatic test_timeout();
      xfer(1'b0, 3'b010, 32'h200, 32'h0, 100, 32'h0, 1'b0);
      total++; if (ncyc !== 4 || lat !== 5 || o_err !== 1'b1 || o_rdata !== 32'h0 || o_mis !== 1'b0) begin
         bad++; $display("FAIL timeout ncyc=%0d lat=%0d err=%b rdata=%h mis=%b want 4/5/1/0/0",
                         ncyc, lat, o_err, o_rdata, o_mis);
      end
      xfer(1'b0, 3'b010, 32'h204, 32'h0, 1, 32'hCAFEF00D, 1'b1);
      total++; if (o_err !== 1'b1 || o_rdata !== 32'h0 || lat !== 3) begin
         bad++; $display("FAIL ack_err err=%b rdata=%h lat=%0d want 1/0/3", o_err, o_rdata, lat);
      end
   endtask

   task automatic test_back_to_back();
      xfer(1'b0, 3'b010, 32'h300, 32'h0, 1, 32'h11112222, 1'b0);
      xfer(1'b0, 3'b001, 32'h302, 32'h0, 2, 32'h7FFF0000, 1'b0);
      total++; if (lat !== 4 || o_rdata !== 32'h00007FFF || ncyc !== 3) begin
         bad++; $display("FAIL b2b_second lat=%0d rdata=%h ncyc=%0d want 4/00007fff/3", lat, o_rdata, ncyc);
      end
   endtask

   task automatic test_reset_mid();
      logic seen;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400; req_wdata = '0;
      @(negedge clk);
      req_valid = 1'b0;
      total++; if (wb_cyc_o !== 1'b1) begin bad++; $display("FAIL rstmid_cyc_before got=%b want=1", wb_cyc_o); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         bad++; $display("FAIL rstmid_after cyc=%b stb=%b ready=%b rspv=%b want 0/0/1/0",
                         wb_cyc_o, wb_stb_o, req_ready, rsp_valid);
      end
      // Stray ack/err while idle must not produce anything.
      seen = 1'b0;
      wb_ack_i = 1'b1; wb_err_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         wb_ack_i = 1'b0; wb_err_i = 1'b0;
         if (rsp_valid || wb_cyc_o) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL idle_stray_ack activity=%b want=0", seen); end
      xfer(1'b0, 3'b010, 32'h500, 32'h0, 1, 32'h12345678, 1'b0);
      total++; if (lat !== 3 || o_rdata !== 32'h12345678 || o_err !== 1'b0) begin
         bad++; $display("FAIL rstmid_next lat=%0d rdata=%h err=%b want 3/12345678/0", lat, o_rdata, o_err);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_load_ext();
      test_store();
      test_misalign();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
